// File: rtl/karatsuba_mult_pipe_if.sv
// Interface: karatsuba_mult_pipe_if
// Purpose : Groups the operand stream (valid/ready/a/b/tag) and the result stream
//           (valid/ready/product/tag) of karatsuba_mult_pipe.
// Ports   : master - the environment: drives operands and out_ready, sees results.
//           slave  - the multiplier: drives in_ready and results, sees operands.
// Config  : KARATSUBA_SIGNED_EN adds the in_signed operand qualifier.
interface karatsuba_mult_pipe_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic [TAG_W-1:0]     in_tag;
`ifdef KARATSUBA_SIGNED_EN
    logic                 in_signed;
`endif
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_p;
    logic [TAG_W-1:0]     out_tag;

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
`ifdef KARATSUBA_SIGNED_EN
        output in_signed,
`endif
        input  in_ready, out_valid, out_p, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
`ifdef KARATSUBA_SIGNED_EN
        input  in_signed,
`endif
        output in_ready, out_valid, out_p, out_tag
    );
endinterface

// File: rtl/karatsuba_mult_pipe.sv
// Module : karatsuba_mult_pipe
// Purpose: Three-stage pipelined Karatsuba multiplier with valid/ready flow
//          control and a tag carried alongside each operation.
//            S1: split operands into halves, form the H+1-bit half sums
//            S2: three half-width products pH, pL, pM
//            S3: mid = pM - pH - pL, recombine into the 2*WIDTH product
//          All stages advance together; a stalled result freezes the whole pipe.
// Ports  : clk   - rising-edge clock
//          rst_n - asynchronous active-low reset
//          bus   - karatsuba_mult_pipe_if.slave (operand and result streams)
// Config : KARATSUBA_SIGNED_EN - adds in_signed; signed operands are multiplied
//          as magnitudes and the product negated in S3.
module karatsuba_mult_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input logic clk,
    input logic rst_n,
    karatsuba_mult_pipe_if.slave bus
);
    localparam int H = WIDTH / 2;

    logic               adv;

    logic               v1_q, v2_q, v3_q;
    logic [H-1:0]       ah_q, al_q, bh_q, bl_q;
    logic [H:0]         sa_q, sb_q;
    logic [TAG_W-1:0]   tag1_q, tag2_q, tag3_q;
    logic [2*H-1:0]     ph_q, pl_q;
    logic [2*H+1:0]     pm_q;
    logic [2*WIDTH-1:0] p3_q;

    logic [WIDTH-1:0]   a_mag_d, b_mag_d;
    logic [H:0]         sa_d, sb_d;
    logic [2*H-1:0]     ph_d, pl_d;
    logic [2*H+1:0]     pm_d;
    logic [2*H+1:0]     mid_d;
    logic [2*WIDTH-1:0] prod_d;
    logic [2*WIDTH-1:0] p3_d;

`ifdef KARATSUBA_SIGNED_EN
    logic neg_d, neg1_q, neg2_q;
`endif

    assign adv          = !v3_q || bus.out_ready;
    assign bus.in_ready = adv;
    assign bus.out_valid = v3_q;
    assign bus.out_p    = p3_q;
    assign bus.out_tag  = tag3_q;

    // The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which still fits unsigned.
    always_comb begin
        a_mag_d = bus.in_a;
        b_mag_d = bus.in_b;
`ifdef KARATSUBA_SIGNED_EN
        neg_d = 1'b0;
        if (bus.in_signed) begin
            if (bus.in_a[WIDTH-1]) a_mag_d = -bus.in_a;
            if (bus.in_b[WIDTH-1]) b_mag_d = -bus.in_b;
            neg_d = bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1];
        end
`endif
        sa_d = {1'b0, a_mag_d[WIDTH-1:H]} + {1'b0, a_mag_d[H-1:0]};
        sb_d = {1'b0, b_mag_d[WIDTH-1:H]} + {1'b0, b_mag_d[H-1:0]};
    end

    always_comb begin
        ph_d = {{H{1'b0}}, ah_q} * {{H{1'b0}}, bh_q};
        pl_d = {{H{1'b0}}, al_q} * {{H{1'b0}}, bl_q};
        pm_d = {{(H+1){1'b0}}, sa_q} * {{(H+1){1'b0}}, sb_q};
    end

    // {pH, pL} is exactly pH<<WIDTH + pL since both are WIDTH bits wide;
    // mid never underflows, and the final sum fits 2*WIDTH bits by construction.
    always_comb begin
        mid_d  = pm_q - {2'b00, ph_q} - {2'b00, pl_q};
        prod_d = {ph_q, pl_q}
               + ({{(2*WIDTH-2*H-2){1'b0}}, mid_d} << H);
        p3_d   = prod_d;
`ifdef KARATSUBA_SIGNED_EN
        if (neg2_q) p3_d = -prod_d;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            ah_q   <= '0;
            al_q   <= '0;
            bh_q   <= '0;
            bl_q   <= '0;
            sa_q   <= '0;
            sb_q   <= '0;
            tag1_q <= '0;
            tag2_q <= '0;
            tag3_q <= '0;
            ph_q   <= '0;
            pl_q   <= '0;
            pm_q   <= '0;
            p3_q   <= '0;
`ifdef KARATSUBA_SIGNED_EN
            neg1_q <= 1'b0;
            neg2_q <= 1'b0;
`endif
        end else if (adv) begin
            v1_q   <= bus.in_valid;
            ah_q   <= a_mag_d[WIDTH-1:H];
            al_q   <= a_mag_d[H-1:0];
            bh_q   <= b_mag_d[WIDTH-1:H];
            bl_q   <= b_mag_d[H-1:0];
            sa_q   <= sa_d;
            sb_q   <= sb_d;
            tag1_q <= bus.in_tag;

            v2_q   <= v1_q;
            ph_q   <= ph_d;
            pl_q   <= pl_d;
            pm_q   <= pm_d;
            tag2_q <= tag1_q;

            v3_q   <= v2_q;
            p3_q   <= p3_d;
            tag3_q <= tag2_q;
`ifdef KARATSUBA_SIGNED_EN
            neg1_q <= neg_d;
            neg2_q <= neg1_q;
`endif
        end
    end
endmodule

// File: tb/tb_karatsuba_mult_pipe.sv
// Testbench for karatsuba_mult_pipe (WIDTH=16, TAG_W=4). Expected products come
// from a plain full-width reference multiply queued at acceptance and compared
// when the result handshake completes.
module tb_karatsuba_mult_pipe;
    localparam int W  = 16;
    localparam int TW = 4;

    typedef struct {
        logic [2*W-1:0] p;
        logic [TW-1:0]  tag;
        int             cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   ir_low = 0;
    bit   lat_chk = 0;
    bit   rnd = 0;
    bit   held_v = 0;
    logic [2*W-1:0] held_p;
    logic [TW-1:0]  held_tag;
    exp_t sb[$];

    karatsuba_mult_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();

    karatsuba_mult_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic s);
        logic [2*W-1:0] xa, xb;
        xa = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        xb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        return xa * xb;
    endfunction

    // Monitor: all handshakes resolve at the next rising edge, so sampling on the
    // falling edge sees exactly the values that edge will act on.
    always @(negedge clk) begin
        logic s;
        exp_t e;
        if (!rst_n) begin
            held_v = 0;
        end else begin
            if (!bus.in_ready) ir_low++;
            if (bus.in_valid && bus.in_ready) begin
                s = 1'b0;
`ifdef KARATSUBA_SIGNED_EN
                s = bus.in_signed;
`endif
                e.p = ref_mul(bus.in_a, bus.in_b, s);
                e.tag = bus.in_tag;
                e.cyc = cyc;
                sb.push_back(e);
            end
            if (bus.out_valid) begin
                if (held_v) begin
                    chk("hold_p", 64'(bus.out_p), 64'(held_p));
                    chk("hold_tag", 64'(bus.out_tag), 64'(held_tag));
                end
                if (!bus.out_ready) begin
                    chk("in_ready_bp", 64'(bus.in_ready), 64'd0);
                    held_v = 1;
                    held_p = bus.out_p;
                    held_tag = bus.out_tag;
                end else begin
                    held_v = 0;
                    chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("out_p", 64'(bus.out_p), 64'(e.p));
                        chk("out_tag", 64'(bus.out_tag), 64'(e.tag));
                        if (lat_chk) chk("latency", 64'(cyc - e.cyc), 64'd3);
                    end
                end
            end else begin
                held_v = 0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] t, input logic s);
        int n;
        bus.in_valid = 1'b1;
        bus.in_a = a;
        bus.in_b = b;
        bus.in_tag = t;
`ifdef KARATSUBA_SIGNED_EN
        bus.in_signed = s;
`else
        if (s) $display("note: signed beat sent to unsigned build");
`endif
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 50);
        if (!bus.in_ready) chk("send_accept", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic [W-1:0] a, b;
        logic [TW-1:0] tg;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_tag = '0;
`ifdef KARATSUBA_SIGNED_EN
        bus.in_signed = 1'b0;
`endif
        bus.out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_p", 64'(bus.out_p), 64'd0);
        chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Max product with the half-sum carry-out, plus latency.
        lat_chk = 1;
        send(16'hFFFF, 16'hFFFF, 4'd5, 1'b0);
        drain();

        // Back-to-back stream: consecutive outputs, in_ready never drops.
        ir_low = 0;
        for (int i = 0; i < 8; i++) send(16'(i), 16'(16'h0100 + i), 4'(i), 1'b0);
        drain();
        chk("b2b_in_ready_low", 64'(ir_low), 64'd0);

        // Boundary operands.
        send(16'h0000, 16'h1234, 4'd1, 1'b0);
        send(16'h1234, 16'h0000, 4'd2, 1'b0);
        send(16'h8000, 16'h8000, 4'd3, 1'b0);
        send(16'hFF00, 16'h00FF, 4'd4, 1'b0);
        send(16'h00FF, 16'hFFFF, 4'd6, 1'b0);
        drain();
        lat_chk = 0;

        // Backpressure: result stalled for 5 clk while 4 beats are offered.
        fork
            begin
                for (int i = 0; i < 4; i++) send(16'(16'hA000 + i * 16'h0111), 16'(16'h7F00 + i), 4'(8 + i), 1'b0);
            end
            begin
                bus.out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) send(16'(16'h1111 * (i + 1)), 16'h0F0F, 4'(12 + i), 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_out_p", 64'(bus.out_p), 64'd0);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        lat_chk = 1;
        send(16'h00AB, 16'h00CD, 4'd7, 1'b0);
        drain();
        lat_chk = 0;

`ifdef KARATSUBA_SIGNED_EN
        send(16'hFFFF, 16'h0001, 4'd1, 1'b1);
        send(16'h8000, 16'h8000, 4'd2, 1'b1);
        send(16'h8000, 16'h0001, 4'd3, 1'b1);
        send(16'hFFFF, 16'h0001, 4'd4, 1'b0);
        drain();
`endif

        // Random operands with random consumer stalls and input gaps.
        rnd = 1;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 7))
                0: a = '1;
                1: a = '0;
                2: a = 16'hFF80;
                default: a = 16'($urandom);
            endcase
            b = (i % 5 == 0) ? 16'hFFFF : 16'($urandom);
            tg = 4'(i);
            send(a, b, tg, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rnd = 0;
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
